// File: rtl/icache_pkg.sv
// Shared types and helpers for the N-way burst instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         MAX_FETCH      = 4;

  // Bit k is set when word blocki+k still lies inside the line.
  function automatic logic [MAX_FETCH-1:0] fetch_mask(input int unsigned blocki,
                                                      input int unsigned block_num,
                                                      input int unsigned fetch_num);
    logic [MAX_FETCH-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < MAX_FETCH; k++) begin
      if (k < fetch_num && blocki + k < block_num)
        m = m | (MAX_FETCH'(1) << k);
    end
    return m;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the I-cache: valid bits, tags and line data with a combinational read port.
module icache_way #(
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_WIDTH   = 20,
  parameter int BLOCK_NUM   = 8,
  localparam int DEPTH      = 1 << INDEX_WIDTH,
  localparam int WORD_W     = $clog2(BLOCK_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INDEX_WIDTH-1:0]   rd_index_i,
  output logic                     rd_valid_o,
  output logic [TAG_WIDTH-1:0]     rd_tag_o,
  output logic [32*BLOCK_NUM-1:0]  rd_line_o,
  input  logic                     wr_en_i,
  input  logic [INDEX_WIDTH-1:0]   wr_index_i,
  input  logic [WORD_W-1:0]        wr_word_i,
  input  logic [31:0]              wr_data_i,
  input  logic                     fill_i,
  input  logic [TAG_WIDTH-1:0]     fill_tag_i,
  input  logic                     fill_valid_i,
  input  logic                     clr_all_i
);

  logic [DEPTH-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [DEPTH];
  logic [31:0]          data_q [DEPTH][BLOCK_NUM];

  // Only the valid bits need reset; tags and data are qualified by them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      valid_q <= '0;
    else if (clr_all_i)
      valid_q <= '0;
    else if (fill_i)
      valid_q[wr_index_i] <= fill_valid_i;
  end

  always_ff @(posedge clk) begin
    if (wr_en_i)
      data_q[wr_index_i][wr_word_i] <= wr_data_i;
    if (fill_i)
      tag_q[wr_index_i] <= fill_tag_i;
  end

  always_comb begin
    rd_valid_o = valid_q[rd_index_i];
    rd_tag_o   = tag_q[rd_index_i];
    for (int w = 0; w < BLOCK_NUM; w++)
      rd_line_o[32*w +: 32] = data_q[rd_index_i][w];
  end

endmodule

// File: rtl/i_cache_burst_nway.sv
// N-way set-associative instruction cache with multi-word fetch and an AXI INCR refill master.
module i_cache_burst_nway
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 5,
  parameter int WAY_NUM      = 2,
  parameter int FETCH_NUM    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_inst_req,
  input  logic [31:0]            cpu_inst_addr,
  output logic                   cpu_inst_addr_ok,
  output logic                   cpu_inst_data_ok,
  output logic [32*FETCH_NUM-1:0] cpu_inst_rdata,
  output logic [FETCH_NUM-1:0]   cpu_inst_mask,
  output logic                   cpu_inst_err,
  input  logic                   invalidate_all,
  output logic [31:0]            araddr,
  output logic [3:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready
);

  localparam int CACHE_DEPTH = 1 << INDEX_WIDTH;
  localparam int BLOCK_NUM   = 1 << (OFFSET_WIDTH - 2);
  localparam int TAG_WIDTH   = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORD_W      = OFFSET_WIDTH - 2;
  localparam int WAY_W       = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [WORD_W-1:0]      req_blocki;
  logic                   unused_addr_lsb;

  assign req_tag         = cpu_inst_addr[31 -: TAG_WIDTH];
  assign req_index       = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_blocki      = cpu_inst_addr[2 +: WORD_W];
  assign unused_addr_lsb = ^cpu_inst_addr[1:0];

  state_e                 state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [WORD_W-1:0]      blocki_q;
  logic [WAY_W-1:0]       victim_q;
  logic                   use_rr_q;
  logic [WORD_W-1:0]      beat_q;
  logic                   err_q;
  logic                   inv_pend_q;
  logic [WAY_W-1:0]       rr_q [CACHE_DEPTH];

  logic [INDEX_WIDTH-1:0]  rd_index;
  logic [WAY_NUM-1:0]      way_valid;
  logic [TAG_WIDTH-1:0]    way_tag  [WAY_NUM];
  logic [32*BLOCK_NUM-1:0] way_line [WAY_NUM];
  logic [WAY_NUM-1:0]      way_wr_en;
  logic [WAY_NUM-1:0]      way_fill;
  logic [WAY_NUM-1:0]      hit_vec;
  logic                    hit;
  logic                    miss;
  logic [WAY_W-1:0]        hit_way;
  logic [WAY_W-1:0]        victim;
  logic                    all_valid;
  logic                    beat_fire;
  logic                    last_fire;
  logic                    err_next;
  logic                    clr_all;
  logic [WAY_W-1:0]        rr_inc;

  assign rd_index = (state_q == S_IDLE) ? req_index : index_q;

  for (genvar g = 0; g < WAY_NUM; g++) begin : g_way
    assign way_wr_en[g] = beat_fire && (victim_q == WAY_W'(g));
    assign way_fill[g]  = last_fire && (victim_q == WAY_W'(g));
    icache_way #(
      .INDEX_WIDTH(INDEX_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .BLOCK_NUM  (BLOCK_NUM)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .rd_index_i  (rd_index),
      .rd_valid_o  (way_valid[g]),
      .rd_tag_o    (way_tag[g]),
      .rd_line_o   (way_line[g]),
      .wr_en_i     (way_wr_en[g]),
      .wr_index_i  (index_q),
      .wr_word_i   (beat_q),
      .wr_data_i   (rdata),
      .fill_i      (way_fill[g]),
      .fill_tag_i  (tag_q),
      .fill_valid_i(!err_next),
      .clr_all_i   (clr_all)
    );
  end

  // A pending invalidate suppresses the lookup so the request retries as a miss.
  always_comb begin
    hit_way = '0;
    victim  = rr_q[req_index];
    for (int w = 0; w < WAY_NUM; w++)
      hit_vec[w] = way_valid[w] && (way_tag[w] == req_tag);
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (hit_vec[w])
        hit_way = WAY_W'(w);
      if (!way_valid[w])
        victim = WAY_W'(w);
    end
    all_valid = &way_valid;
    hit  = (state_q == S_IDLE) && cpu_inst_req && !invalidate_all && (|hit_vec);
    miss = (state_q == S_IDLE) && cpu_inst_req && !invalidate_all && !(|hit_vec);
  end

  assign beat_fire = (state_q == S_R) && rvalid;
  assign last_fire = beat_fire && rlast;
  assign err_next  = err_q || (rresp != AXI_RESP_OKAY)
                   || (rlast && (beat_q != WORD_W'(BLOCK_NUM - 1)));
  assign clr_all   = ((state_q == S_IDLE) && invalidate_all)
                   || ((state_q == S_RESP) && (inv_pend_q || invalidate_all));
  assign rr_inc    = (rr_q[index_q] == WAY_W'(WAY_NUM - 1)) ? '0 : rr_q[index_q] + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (miss)      state_d = S_AR;
      S_AR:   if (arready)   state_d = S_R;
      S_R:    if (last_fire) state_d = S_RESP;
      S_RESP:                state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tag_q      <= '0;
      index_q    <= '0;
      blocki_q   <= '0;
      victim_q   <= '0;
      use_rr_q   <= 1'b0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      inv_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (miss) begin
        tag_q    <= req_tag;
        index_q  <= req_index;
        blocki_q <= req_blocki;
        victim_q <= victim;
        use_rr_q <= all_valid;
      end
      if (beat_fire) begin
        beat_q <= rlast ? '0 : beat_q + 1'b1;
        err_q  <= err_next;
      end else if (state_q == S_RESP) begin
        err_q <= 1'b0;
      end
      if (state_q == S_RESP)
        inv_pend_q <= 1'b0;
      else if (state_q != S_IDLE && invalidate_all)
        inv_pend_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CACHE_DEPTH; i++)
        rr_q[i] <= '0;
    end else if (last_fire && use_rr_q) begin
      rr_q[index_q] <= rr_inc;
    end
  end

  logic [WAY_W-1:0]        sel_way;
  logic [WORD_W-1:0]       sel_blocki;
  logic [32*BLOCK_NUM-1:0] sel_line;
  logic [32*FETCH_NUM-1:0] fetch_data;
  logic [MAX_FETCH-1:0]    mask_full;

  // Hits read the matching way at the live address; RESP reads the freshly refilled victim.
  always_comb begin
    sel_way    = (state_q == S_IDLE) ? hit_way : victim_q;
    sel_blocki = (state_q == S_IDLE) ? req_blocki : blocki_q;
    sel_line   = way_line[sel_way];
    fetch_data = '0;
    for (int k = 0; k < FETCH_NUM; k++) begin
      if (int'(sel_blocki) + k < BLOCK_NUM)
        fetch_data[32*k +: 32] = sel_line[32*(int'(sel_blocki) + k) +: 32];
    end
    mask_full = fetch_mask(32'(sel_blocki), BLOCK_NUM, FETCH_NUM);
  end

  assign cpu_inst_data_ok = hit || (state_q == S_RESP);
  assign cpu_inst_addr_ok = hit || ((state_q == S_AR) && arready);
  assign cpu_inst_rdata   = cpu_inst_data_ok ? fetch_data : '0;
  assign cpu_inst_mask    = cpu_inst_data_ok ? mask_full[FETCH_NUM-1:0] : '0;
  assign cpu_inst_err     = (state_q == S_RESP) && err_q;

  assign arvalid = (state_q == S_AR);
  assign araddr  = arvalid ? {tag_q, index_q, {OFFSET_WIDTH{1'b0}}} : '0;
  assign arlen   = 4'(BLOCK_NUM - 1);
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign rready  = (state_q == S_R);

  a_single_hit: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_IDLE && cpu_inst_req) |-> $onehot0(hit_vec));
  a_req_held_in_ar: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_AR) |-> cpu_inst_req);

endmodule

// File: doc/i_cache_burst_nway.md
Name: i_cache_burst_nway

Overview:
Parametrised successor to the 2-way burst instruction cache. It is an N-way set-associative I-cache with a configurable multi-word fetch group toward the CPU fetch stage and an AXI-style INCR burst read master toward the memory side. Added behaviour over the previous generation:
- invalid-first / per-set round-robin replacement;
- line valid set only on a successful last beat;
- AXI read error reporting;
- whole-cache invalidate.

Parameters:
INDEX_WIDTH, 7, set index bits; CACHE_DEPTH = 2^INDEX_WIDTH
OFFSET_WIDTH, 5, line offset bits; BLOCK_NUM = 2^(OFFSET_WIDTH-2) words per line, 2..16
WAY_NUM, 2, associativity, power of 2, 1..8
FETCH_NUM, 2, words returned per fetch, 1..4, must be <= BLOCK_NUM

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cpu_inst_req  in  1  fetch request; req and addr held stable until addr_ok
cpu_inst_addr  in  32  fetch address, word aligned
cpu_inst_addr_ok  out  1  request accepted
cpu_inst_data_ok  out  1  fetch group valid this cycle
cpu_inst_rdata  out  32*FETCH_NUM  word k at bits [32k+31:32k]; word k = addr+4k
cpu_inst_mask  out  FETCH_NUM  bit k set if word k is valid
cpu_inst_err  out  1  fetch group came from a burst with a non-OKAY response
invalidate_all  in  1  pulse; clear all valid bits
araddr  out  32  line-aligned burst address
arlen  out  4  constant BLOCK_NUM-1
arsize  out  3  constant 3'b010
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data beat
rresp  in  2  beat response; non-zero means error
rlast  in  1  last beat
rvalid  in  1  read data valid
rready  out  1  read data ready

Behaviour:
- Reset is asynchronous. It forces state IDLE and clears all valid bits, round-robin pointers, beat counter and sticky error. While rst is high, every output is 0 except the constants arlen/arsize/arburst. A reset mid-burst abandons the burst; the AXI slave is reset with the same rst.
- States: IDLE, AR, R, RESP.
- Hit (IDLE, req, some way valid with matching tag):
  - addr_ok = data_ok = 1 combinationally in the same cycle; zero-latency hit.
  - rdata word k = line[blocki+k] when blocki+k < BLOCK_NUM; otherwise the word is 0 and its mask bit is 0. mask bit 0 is always 1.
  - More than one matching way is illegal; flag it with an assertion.
- Miss (IDLE, req, no hit):
  - Capture tag, index, blocki and victim way; go to AR.
  - Victim is the lowest-numbered invalid way. If all ways are valid, it is rr_ptr[index], and rr_ptr[index] increments modulo WAY_NUM after the refill completes.
- AR:
  - arvalid = 1 and araddr = {tag_save, index_save, OFFSET_WIDTH'b0}, held until arready.
  - On the handshake cycle addr_ok = 1 and state goes to R. No other request is accepted until the data_ok for this miss.
- R:
  - rready = 1. Each beat writes rdata into way victim, set index_save, word beat_cnt, then beat_cnt++.
  - Any beat with rresp != 0 sets err_sticky.
  - On the rlast beat: valid[victim][index_save] <= !err_sticky_next, tag written, state goes to RESP.
  - The valid bit is never set on intermediate beats.
  - If rlast arrives with beat_cnt != BLOCK_NUM-1, treat it as an error: line stays invalid.
- RESP (one cycle):
  - data_ok = 1; rdata/mask are built from the refill line at blocki_save; err = err_sticky.
  - Clear err_sticky, then go to IDLE.
  - Miss latency = AR wait + BLOCK_NUM beats + 1.
- invalidate_all:
  - In IDLE: all valid bits clear at the next edge, and no hit is reported in that cycle.
  - In AR/R/RESP: latched and applied on entry to IDLE. The refilled line is also cleared, but the pending RESP still returns its data.
- Simultaneous invalidate_all and req in IDLE: the invalidate wins, addr_ok = 0, and the request retries next cycle as a miss.
- beat_cnt wraps to 0 after rlast.
- A request dropped before addr_ok is legal in IDLE; it is illegal in AR (flag with an assertion).

Decomposition:
- Shared package icache_pkg holds:
  - the state enum;
  - AXI_BURST_INCR = 2'b01, AXI_SIZE_4B = 3'b010, AXI_RESP_OKAY = 2'b00;
  - a function fetch_mask(blocki) returning the FETCH_NUM mask.
- One sub-module, icache_way: instantiated WAY_NUM times. It holds the valid/tag/data arrays for one way and provides a combinational read port, a word write port and a valid-clear-all input.

Test Plan:
- Cold miss, 0x0000_1000, arready after 2 cycles, 8 OKAY beats 0xA0..0xA7 -> araddr 0x1000, arlen 7; addr_ok on AR handshake; data_ok 1 cycle after rlast with rdata = {0xA1, 0xA0}, mask 2'b11, err 0.
- Hit 0x0000_101C after that refill -> addr_ok = data_ok in the same cycle; word0 0xA7, word1 0, mask 2'b01.
- WAY_NUM=2: misses 0x1000, 0x5000, 0x9000 (same index), each refilled -> ways 0, 1, then 0 replaced (rr_ptr); a re-access to 0x1000 misses.
- Beat 3 of a refill returns rresp 2'b10 -> data_ok with err = 1; a re-access to the same address misses and issues a new AR.
- invalidate_all pulsed during R -> current fetch completes with correct data; the next access to the same line misses.
- rst asserted mid-burst after beat 4 -> arvalid/rready drop immediately; after release, the access misses and the full line is refetched correctly.
